// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: definitions shared by the ROM arbiter and its winner-select
// sub-module.
//   - arb_state_t : 2-bit transaction FSM state
//   - AW_DEF, DW_DEF : default ROM address and data widths
//   - RSP_LATENCY : number of cycles from the request-sampling edge to rsp_valid
package rom_arb_pkg;

  localparam int AW_DEF      = 2;
  localparam int DW_DEF      = 4;
  localparam int RSP_LATENCY = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_CAPT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rom_arbiter_rr_select.sv
// rr_select: combinational winner search for the ROM arbiter.
//   i_req  [NREQ] : request levels
//   i_last [IDW]  : index of the previous winner (round-robin build only)
//   o_any         : at least one request is pending
//   o_win  [IDW]  : index of the winning requester (0 when o_any is low)
// Build option: ROM_ARB_FIXED_PRIO_EN turns this into a plain lowest-index
// priority encoder, and the i_last port disappears.
module rr_select
  import rom_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] i_req,
`ifndef ROM_ARB_FIXED_PRIO_EN
  input  logic [IDW-1:0]  i_last,
`endif
  output logic            o_any,
  output logic [IDW-1:0]  o_win
);

  int w_best;
  int w_dist;

  // Each requester gets a distance from the search start; the set request
  // with the smallest distance wins. For round-robin the start is last+1 with
  // wrap-around, so the distance is (i - last - 1) mod NREQ.
  always_comb begin
    o_any  = |i_req;
    o_win  = '0;
    w_best = NREQ;
    w_dist = 0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      w_dist = i;
`else
      w_dist = i - int'(i_last) - 1;
      if (w_dist < 0) w_dist = w_dist + NREQ;
`endif
      if (i_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_win  = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one single-port, 1-cycle-registered-read ROM between
// NREQ requesters. One transaction at a time; the response comes back tagged
// with the requester index.
//   clk, reset          : clock, synchronous active-high reset
//   req [NREQ]          : request levels (only looked at in IDLE)
//   req_addr [NREQ*AW]  : packed addresses, requester i at [i*AW +: AW]
//   gnt [NREQ]          : one-hot grant, high for one cycle
//   busy                : transaction in flight
//   rom_addr [AW]       : registered ROM address
//   rom_data [DW]       : ROM read data
//   rsp_valid           : one-cycle response strobe
//   rsp_id [IDW]        : requester index of the response
//   rsp_data [DW]       : captured ROM word, held until the next capture
// Build option: ROM_ARB_FIXED_PRIO_EN selects lowest-index-wins arbitration
// instead of round-robin; timing is unchanged.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates, registers rom_addr and gnt
// ADDR  | gnt high; ROM samples rom_addr at the end of this cycle
// WAIT  | ROM output settles
// CAPT  | rom_data captured into rsp_data at the end of this cycle
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int IDW  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_data,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data
);

  arb_state_t        r_state, w_state_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
  logic              r_busy, w_busy_nxt;
  logic [AW-1:0]     r_rom_addr, w_rom_addr_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [IDW-1:0]    r_rsp_id, w_rsp_id_nxt;
  logic [DW-1:0]     r_rsp_data, w_rsp_data_nxt;
  logic              w_any;
  logic [IDW-1:0]    w_win;
  logic [AW-1:0]     w_addr_sel;
`ifndef ROM_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]    r_last, w_last_nxt;
`endif

  rr_select #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_sel (
    .i_req  (req),
`ifndef ROM_ARB_FIXED_PRIO_EN
    .i_last (r_last),
`endif
    .o_any  (w_any),
    .o_win  (w_win)
  );

  always_comb begin
    w_addr_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) w_addr_sel = req_addr[i*AW +: AW];
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = '0;
    w_busy_nxt      = r_busy;
    w_rom_addr_nxt  = r_rom_addr;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_id_nxt    = r_rsp_id;
    w_rsp_data_nxt  = r_rsp_data;
`ifndef ROM_ARB_FIXED_PRIO_EN
    w_last_nxt      = r_last;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_rom_addr_nxt = w_addr_sel;
          w_gnt_nxt      = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
          w_rsp_id_nxt   = w_win;
          w_busy_nxt     = 1'b1;
`ifndef ROM_ARB_FIXED_PRIO_EN
          w_last_nxt     = w_win;
`endif
          w_state_nxt    = ST_ADDR;
        end
      end
      ST_ADDR: w_state_nxt = ST_WAIT;
      ST_WAIT: w_state_nxt = ST_CAPT;
      ST_CAPT: begin
        w_rsp_data_nxt  = rom_data;
        w_rsp_valid_nxt = 1'b1;
        w_busy_nxt      = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reset drops any in-flight read: the FSM returns to IDLE before CAPT can
  // raise rsp_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_busy      <= 1'b0;
      r_rom_addr  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      r_last      <= IDW'(NREQ - 1);
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_busy      <= w_busy_nxt;
      r_rom_addr  <= w_rom_addr_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_id    <= w_rsp_id_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
`ifndef ROM_ARB_FIXED_PRIO_EN
      r_last      <= w_last_nxt;
`endif
    end
  end

  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign rom_addr  = r_rom_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: self-checking bench for rom_arbiter (NREQ=2) with a
// registered-read ROM model. Expected responses are queued when a request is
// driven and popped when rsp_valid is seen. Compile with
// ROM_ARB_FIXED_PRIO_EN to select the fixed-priority expectations.
module tb_rom_arbiter;
  import rom_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 2;
  localparam int DW   = 4;
  localparam int IDW  = 1;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_data;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;

  rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .busy      (busy),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom_mem [4];
  initial begin
    rom_mem[0] = 4'b1110;
    rom_mem[1] = 4'b0010;
    rom_mem[2] = 4'b1111;
    rom_mem[3] = 4'b0100;
  end
  always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];

  typedef struct {
    logic [1:0] req;
    logic [1:0] a0;
    logic [1:0] a1;
    logic [1:0] gnt_rr;
    logic       id_rr;
    logic [3:0] data_rr;
    logic [1:0] gnt_fp;
    logic       id_fp;
    logic [3:0] data_fp;
  } vec_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } rsp_t;

  vec_t vecs [8];
  rsp_t sb [$];
  rsp_t m_exp;
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL spurious_rsp: got id=%0d data=%b expected no response at %0t",
                 rsp_id, rsp_data, $time);
      end else begin
        m_exp = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(m_exp.id));
        chk("rsp_data", 32'(rsp_data), 32'(m_exp.data));
      end
    end
  end

  // Called at a negedge in an IDLE cycle; returns at the negedge of the
  // response cycle, which is again IDLE.
  task automatic run_txn(input logic [1:0] r, input logic [1:0] a0, input logic [1:0] a1,
                         input logic [1:0] eg, input logic eid, input logic [3:0] edata);
    req      = r;
    req_addr = {a1, a0};
    sb.push_back('{eid, edata});
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy_gnt_cycle", 32'(busy), 32'd1);
    chk("rom_addr", 32'(rom_addr), 32'(eid ? a1 : a0));
    @(negedge clk);
    chk("gnt_one_cycle", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("rsp_not_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [1:0] v_gnt;
  logic       v_id;
  logic [3:0] v_data;

  initial begin
    vecs[0] = '{2'b11, 2'b00, 2'b10, 2'b01, 1'b0, 4'b1110, 2'b01, 1'b0, 4'b1110};
    vecs[1] = '{2'b11, 2'b00, 2'b10, 2'b10, 1'b1, 4'b1111, 2'b01, 1'b0, 4'b1110};
    vecs[2] = '{2'b11, 2'b00, 2'b10, 2'b01, 1'b0, 4'b1110, 2'b01, 1'b0, 4'b1110};
    vecs[3] = '{2'b01, 2'b11, 2'b00, 2'b01, 1'b0, 4'b0100, 2'b01, 1'b0, 4'b0100};
    vecs[4] = '{2'b10, 2'b00, 2'b01, 2'b10, 1'b1, 4'b0010, 2'b10, 1'b1, 4'b0010};
    vecs[5] = '{2'b10, 2'b00, 2'b11, 2'b10, 1'b1, 4'b0100, 2'b10, 1'b1, 4'b0100};
    vecs[6] = '{2'b11, 2'b01, 2'b00, 2'b01, 1'b0, 4'b0010, 2'b01, 1'b0, 4'b0010};
    vecs[7] = '{2'b11, 2'b10, 2'b01, 2'b10, 1'b1, 4'b0010, 2'b01, 1'b0, 4'b1111};

    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    chk("idle_no_gnt", 32'(gnt), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      v_gnt  = vecs[i].gnt_fp;
      v_id   = vecs[i].id_fp;
      v_data = vecs[i].data_fp;
`else
      v_gnt  = vecs[i].gnt_rr;
      v_id   = vecs[i].id_rr;
      v_data = vecs[i].data_rr;
`endif
      run_txn(vecs[i].req, vecs[i].a0, vecs[i].a1, v_gnt, v_id, v_data);
    end
    req = '0;

    // Reset during WAIT: the read is dropped, then a fresh request completes.
    req      = 2'b01;
    req_addr = {2'b00, 2'b01};
    @(negedge clk);
    chk("rstmid_gnt", 32'(gnt), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_gnt_clear", 32'(gnt), 32'd0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_txn(2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 4'b0010);
    req = '0;

    // req1 pulsed while busy must be ignored.
    req      = 2'b01;
    req_addr = {2'b00, 2'b10};
    sb.push_back('{1'b0, 4'b1111});
    @(negedge clk);
    chk("pulse_gnt0", 32'(gnt), 32'd1);
    req      = 2'b10;
    req_addr = {2'b11, 2'b10};
    @(negedge clk);
    chk("pulse_gnt_clear", 32'(gnt), 32'd0);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("pulse_rsp_valid", 32'(rsp_valid), 32'd1);
    repeat (6) begin
      @(negedge clk);
      chk("pulse_no_gnt", 32'(gnt), 32'd0);
      chk("pulse_no_rsp", 32'(rsp_valid), 32'd0);
      chk("rsp_data_hold", 32'(rsp_data), 32'b1111);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares one single-port synchronous-read ROM (4 words x 4 bits, 1-cycle registered read) between NREQ requesters.
- Each requester asserts a request with an address. The arbiter grants one requester at a time, round-robin.
- The arbiter drives the ROM address, then returns the data word tagged with the requester ID.
- Sits between the ROM instance and the client blocks. It is the ROM's only address driver.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 2, ROM address width.
- DW, 4, ROM data width.
- IDW, 1, requester ID width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level.
- req_addr  input  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- gnt  output  NREQ  one-hot grant pulse, registered.
- busy  output  1  high while a transaction is in flight.
- rom_addr  output  AW  address to the ROM, registered.
- rom_data  input  DW  ROM read data; valid the cycle after the ROM samples rom_addr.
- rsp_valid  output  1  one-cycle pulse; rsp_data and rsp_id are valid.
- rsp_id  output  IDW  index of the requester the response belongs to.
- rsp_data  output  DW  captured ROM word.

Behaviour:
- Reset (synchronous, active-high; sampled only on posedge clk):
  - FSM goes to IDLE.
  - gnt=0, busy=0, rom_addr=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - RR pointer last=NREQ-1, so requester 0 wins first.
- FSM states: IDLE, ADDR, WAIT, CAPT.
- IDLE:
  - If any req bit is set at the edge: pick winner w, the first set bit searching from last+1 with wrap-around modulo NREQ.
  - At that edge: rom_addr<=req_addr[w], gnt<=onehot(w), rsp_id<=w, last<=w, busy<=1, go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - gnt is high for this single cycle; it clears at the next edge.
  - The ROM samples rom_addr at the edge ending this cycle.
  - Go to WAIT.
- WAIT: rom_data becomes valid during this cycle. Go to CAPT.
- CAPT:
  - rsp_data<=rom_data, rsp_valid<=1 (pulse one cycle), busy<=0, go to IDLE.
  - Arbitration restarts in the following IDLE cycle.
- Latency and throughput:
  - Edge k samples a request in IDLE; gnt is high in cycle k+1; rsp_valid is high in cycle k+4.
  - Throughput: one transaction per 4 cycles.
- Handshake rules:
  - A requester holds req and req_addr stable until it sees gnt.
  - It deasserts req in the gnt cycle or issues a new request; no queueing.
  - req is ignored outside IDLE.
  - Dropping req before grant withdraws the request silently.
- Simultaneous requests: exactly one grant per transaction. A requester that stays asserted is served within NREQ transactions (no starvation).
- Single requester repeating: it is granted every transaction; the pointer still advances to it.
- rom_addr holds its value between transactions. rsp_data holds its value until the next CAPT.
- Reset mid-transaction: the in-flight read is discarded and no rsp_valid is issued. The requester must re-request.
- Widths: rsp_id is the zero-extended winner index. Out-of-range req bits do not exist (width = NREQ).

Optional Feature:
- ROM_ARB_FIXED_PRIO_EN defined:
  - Winner is the lowest-index set req bit; the RR pointer is not implemented.
  - Starvation of higher indices is allowed.
- Undefined: round-robin as described above.
- Latency and all other behaviour are identical in both builds.

Decomposition:
- Shared package rom_arb_pkg:
  - FSM state typedef (IDLE, ADDR, WAIT, CAPT, 2-bit encoding).
  - Defaults for AW/DW.
  - Constant RSP_LATENCY=4.
- One natural sub-module: rr_select.
  - Combinational winner search given req and last, NREQ-parameterised.
  - Under ROM_ARB_FIXED_PRIO_EN it reduces to a priority encoder.
- The FSM, registers and ROM interface stay in rom_arbiter.

Test Plan:
- ROM model contents 00:1110, 01:0010, 10:1111, 11:0100.
- Reset held 2 cycles, then released -> all outputs 0, FSM in IDLE, no gnt.
- req=01, addr0=11 -> gnt=01 one cycle later; rsp_valid 4 cycles after request edge with rsp_id=0, rsp_data=0100.
- req=11 held, addr0=00, addr1=10 -> grants alternate 01,10,01; responses 1110(id0), 1111(id1), 1110(id0); gnt never two-hot.
- Same stimulus with ROM_ARB_FIXED_PRIO_EN -> req0 granted every transaction, rsp_data 1110 each time, id1 never served.
- reset asserted during WAIT of a transaction to addr 01 -> no rsp_valid; busy=0 next cycle; fresh request to 01 returns 0010.
- req1 pulsed for 1 cycle while busy -> ignored, no gnt to req1, no spurious response.
